// File: rtl/online_test_sequencer_if.sv
// Operator-side bus: the sequencer (master) drives digits and control into the
// online operator under test (slave) and receives its output digit stream.
interface online_test_sequencer_if #(
  parameter int DIGIT_W = 3
);
  logic               op_reset;
  logic               op_en;
  logic [DIGIT_W-1:0] xi;
  logic [DIGIT_W-1:0] yi;
  logic [DIGIT_W-1:0] zi;

  modport master (output op_reset, op_en, xi, yi, input zi);
  modport slave  (input op_reset, op_en, xi, yi, output zi);
endinterface

// File: rtl/online_test_sequencer.sv
// Online-operator test sequencer: feeds latched operand digits MSD-first, captures and checks the result.
// Optional run/fail counters are built when ONLINE_TEST_SEQUENCER_ERR_COUNT_EN is defined.
module online_test_sequencer #(
  parameter int N_DIGITS = 6,
  parameter int DIGIT_W  = 3,
  parameter int DELAY    = 2,
  parameter int IDX_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [N_DIGITS*DIGIT_W-1:0]     x_vec,
  input  logic [N_DIGITS*DIGIT_W-1:0]     y_vec,
  input  logic [(N_DIGITS+1)*DIGIT_W-1:0] exp_vec,
  online_test_sequencer_if.master         op,
  output logic [(N_DIGITS+1)*DIGIT_W-1:0] result,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [IDX_W-1:0]                first_err,
  output logic [15:0]                     run_count,
  output logic [15:0]                     fail_count
);

  localparam int VW = N_DIGITS * DIGIT_W;
  localparam int RW = VW + DIGIT_W;
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(N_DIGITS + DELAY - 1);
  localparam logic [IDX_W-1:0] CAP_T  = IDX_W'(DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   t_q, t_d;
  logic [VW-1:0]      x_q, x_d;
  logic [VW-1:0]      y_q, y_d;
  logic [RW-1:0]      exp_q, exp_d;
  logic [RW-1:0]      result_q, result_d;
  logic               op_reset_q, op_reset_d;
  logic               op_en_q, op_en_d;
  logic [DIGIT_W-1:0] xi_q, xi_d;
  logic [DIGIT_W-1:0] yi_q, yi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [IDX_W-1:0]   first_err_q, first_err_d;
  logic [IDX_W-1:0]   t_nxt;
  logic [IDX_W-1:0]   cap_idx;
  logic               cmp_pass;
  logic [IDX_W-1:0]   cmp_err;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
  logic [15:0]        run_cnt_q, run_cnt_d;
  logic [15:0]        fail_cnt_q, fail_cnt_d;
`endif

  // Digit k of an operand, MSD = 0; indices past the last digit shift out to zero.
  function automatic logic [DIGIT_W-1:0] op_digit(input logic [VW-1:0] v, input logic [IDX_W-1:0] k);
    logic [VW-1:0] s;
    s = v << (int'(k) * DIGIT_W);
    return s[VW-1 -: DIGIT_W];
  endfunction

  // Bitwise digit comparison; scanning from LSD upward leaves the lowest MSD-first index.
  always_comb begin
    cmp_pass = 1'b1;
    cmp_err  = '1;
    for (int k = N_DIGITS; k >= 0; k--) begin
      cmp_err  = (result_q[(N_DIGITS-k)*DIGIT_W +: DIGIT_W] != exp_q[(N_DIGITS-k)*DIGIT_W +: DIGIT_W])
                 ? IDX_W'(k) : cmp_err;
      cmp_pass = cmp_pass & (result_q[(N_DIGITS-k)*DIGIT_W +: DIGIT_W] == exp_q[(N_DIGITS-k)*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    x_d         = x_q;
    y_d         = y_q;
    exp_d       = exp_q;
    result_d    = result_q;
    op_reset_d  = 1'b0;
    op_en_d     = 1'b0;
    xi_d        = '0;
    yi_d        = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = pass_q;
    first_err_d = first_err_q;
    t_nxt       = t_q + IDX_W'(1);
    cap_idx     = t_q - CAP_T;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
    run_cnt_d   = run_cnt_q;
    fail_cnt_d  = fail_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_CLEAR;
          x_d        = x_vec;
          y_d        = y_vec;
          exp_d      = exp_vec;
          result_d   = '0;
          t_d        = '0;
          op_reset_d = 1'b1;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          op_en_d = 1'b1;
          xi_d    = op_digit(x_q, '0);
          yi_d    = op_digit(y_q, '0);
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        // The first DELAY-1 output digits are operator warm-up and are not captured.
        for (int k = 0; k <= N_DIGITS; k++) begin
          result_d[(N_DIGITS-k)*DIGIT_W +: DIGIT_W] =
            ((t_q >= CAP_T) && (cap_idx == IDX_W'(k))) ? op.zi
                                                       : result_q[(N_DIGITS-k)*DIGIT_W +: DIGIT_W];
        end
        if (abort) begin
          state_d = S_IDLE;
        end else if (t_q == LAST_T) begin
          state_d = S_CHECK;
          busy_d  = 1'b1;
        end else begin
          t_d     = t_nxt;
          op_en_d = 1'b1;
          xi_d    = op_digit(x_q, t_nxt);
          yi_d    = op_digit(y_q, t_nxt);
          busy_d  = 1'b1;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_DONE;
          busy_d      = 1'b1;
          done_d      = 1'b1;
          pass_d      = cmp_pass;
          first_err_d = cmp_err;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
          run_cnt_d   = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;
          fail_cnt_d  = (cmp_pass || (fail_cnt_q == 16'hFFFF)) ? fail_cnt_q : fail_cnt_q + 16'd1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      op_reset_q  <= 1'b0;
      op_en_q     <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      first_err_q <= '1;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
      run_cnt_q   <= 16'h0000;
      fail_cnt_q  <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      x_q         <= x_d;
      y_q         <= y_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      op_reset_q  <= op_reset_d;
      op_en_q     <= op_en_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      first_err_q <= first_err_d;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
      run_cnt_q   <= run_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
`endif
    end
  end

  assign op.op_reset = op_reset_q;
  assign op.op_en    = op_en_q;
  assign op.xi       = xi_q;
  assign op.yi       = yi_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign first_err   = first_err_q;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
  assign run_count   = run_cnt_q;
  assign fail_count  = fail_cnt_q;
`else
  assign run_count   = 16'h0000;
  assign fail_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_online_test_sequencer.sv
// Scoreboard bench for online_test_sequencer: a stub operator computes (xi+yi) delayed one cycle
// (or constant zero); expected results come from a digit-level model of the run.
module tb_online_test_sequencer;
  localparam int N   = 6;
  localparam int W   = 3;
  localparam int D   = 2;
  localparam int IW  = 4;
  localparam int VW  = N * W;
  localparam int RW  = (N + 1) * W;
  localparam int LAT = N + D + 3;

  typedef struct {
    logic [RW-1:0] res;
    logic          pas;
    logic [IW-1:0] ferr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [VW-1:0] x_vec, y_vec;
  logic [RW-1:0] exp_vec, result;
  logic          busy, done, pass;
  logic [IW-1:0] first_err;
  logic [15:0]   run_count, fail_count;
  logic [W-1:0]  stub_q;
  int            mode;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          last_pass = 1'b0;
  logic [IW-1:0] last_ferr = '1;
  int            run_cnt = 0;
  int            fail_cnt = 0;

  online_test_sequencer_if #(.DIGIT_W(W)) opif ();

  online_test_sequencer #(.N_DIGITS(N), .DIGIT_W(W), .DELAY(D), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .x_vec      (x_vec),
    .y_vec      (y_vec),
    .exp_vec    (exp_vec),
    .op         (opif),
    .result     (result),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .first_err  (first_err),
    .run_count  (run_count),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Operator stub with online delay 1 per step.
  always_ff @(posedge clk) begin
    if (opif.op_reset) stub_q <= '0;
    else if (opif.op_en) stub_q <= opif.xi + opif.yi;
  end
  assign opif.zi = (mode == 0) ? '0 : stub_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] dig(input logic [VW-1:0] v, input int k);
    return v[(N-1-k)*W +: W];
  endfunction

  // Result digit k (MSD first) is the stub output for operand digit k; the extra LSD sees zero inputs.
  function automatic exp_t expect_run(input logic [VW-1:0] x, input logic [VW-1:0] y,
                                      input logic [RW-1:0] e, input int m);
    exp_t r;
    r.res  = '0;
    r.pas  = 1'b1;
    r.ferr = '1;
    for (int k = 0; k < N; k++) begin
      if (m != 0) r.res[(N-k)*W +: W] = dig(x, k) + dig(y, k);
    end
    for (int k = 0; k <= N; k++) begin
      if (r.pas && (r.res[(N-k)*W +: W] != e[(N-k)*W +: W])) begin
        r.pas  = 1'b0;
        r.ferr = IW'(k);
      end
    end
    return r;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected run.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(1'b0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("pass", 32'(pass), 32'(e.pas));
        chk("first_err", 32'(first_err), 32'(e.ferr));
        last_pass = e.pas;
        last_ferr = e.ferr;
`ifdef ONLINE_TEST_SEQUENCER_ERR_COUNT_EN
        if (run_cnt < 65535) run_cnt++;
        if (!e.pas && fail_cnt < 65535) fail_cnt++;
`endif
        chk("run_count", 32'(run_count), 32'(run_cnt));
        chk("fail_count", 32'(fail_count), 32'(fail_cnt));
      end
    end
  end

  task automatic do_run(input logic [VW-1:0] x, input logic [VW-1:0] y, input logic [RW-1:0] e,
                        input int m, input int abort_cyc, input int extra_start_cyc);
    int t;
    mode = m;
    if (abort_cyc == 0) sb.push_back(expect_run(x, y, e, m));
    x_vec   = x;
    y_vec   = y;
    exp_vec = e;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      t = c - 2;
      if (abort_cyc == 0 || c <= abort_cyc) begin
        chk("op_reset", 32'(opif.op_reset), 32'(c == 1));
        chk("op_en", 32'(opif.op_en), 32'(c >= 2 && c <= N + D + 1));
        chk("xi", 32'(opif.xi), (t >= 0 && t < N) ? 32'(dig(x, t)) : 32'd0);
        chk("yi", 32'(opif.yi), (t >= 0 && t < N) ? 32'(dig(y, t)) : 32'd0);
        chk("busy", 32'(busy), 32'd1);
        chk("done_timing", 32'(done), 32'(c == LAT));
      end else if (c == abort_cyc + 1) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_op_en", 32'(opif.op_en), 32'd0);
        chk("abort_pass_kept", 32'(pass), 32'(last_pass));
        chk("abort_ferr_kept", 32'(first_err), 32'(last_ferr));
      end else begin
        chk("abort_no_done", 32'(done), 32'd0);
      end
      abort = (c == abort_cyc);
      start = (c == extra_start_cyc);
      if (c == 1) begin
        x_vec   = VW'($urandom);
        y_vec   = VW'($urandom);
        exp_vec = RW'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_after_run_busy", 32'(busy), 32'd0);
    chk("idle_after_run_done", 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] rx, ry;
    logic [RW-1:0] re, msk;
    exp_t          mr;
    int            m, sel, ab, k;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    x_vec = '0; y_vec = '0; exp_vec = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_first_err", 32'(first_err), 32'hF);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_op_en", 32'(opif.op_en), 32'd0);
    chk("rst_op_reset", 32'(opif.op_reset), 32'd0);
    chk("rst_run_count", 32'(run_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_run('0, '0, '0, 0, 0, 0);
    do_run(18'o123456, '0, 21'o1234560, 1, 0, 0);
    do_run(18'o123456, '0, 21'o1237560, 1, 0, 0);
    do_run(VW'($urandom), VW'($urandom), RW'($urandom), 1, 0, 5);
    do_run(VW'($urandom), VW'($urandom), RW'($urandom), 1, 4, 0);

    // abort and start together in IDLE: the start must be dropped
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_op_reset", 32'(opif.op_reset), 32'd0);

    for (int i = 0; i < 30; i++) begin
      m   = int'($urandom_range(0, 1));
      rx  = VW'($urandom);
      ry  = VW'($urandom);
      mr  = expect_run(rx, ry, '0, m);
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        re = mr.res;
      end else if (sel == 1) begin
        k   = int'($urandom_range(0, N));
        msk = RW'($urandom_range(1, 7)) << ((N - k) * W);
        re  = mr.res ^ msk;
      end else begin
        re = RW'($urandom);
      end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT - 1)) : 0;
      do_run(rx, ry, re, m, ab, 0);
    end

    // asynchronous reset in the middle of RUN (t=4)
    mode    = 1;
    x_vec   = VW'($urandom);
    y_vec   = VW'($urandom);
    exp_vec = RW'($urandom);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_op_en", 32'(opif.op_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op_en", 32'(opif.op_en), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pass", 32'(pass), 32'd0);
    chk("midrst_first_err", 32'(first_err), 32'hF);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_xi", 32'(opif.xi), 32'd0);
    sb.delete();
    last_pass = 1'b0;
    last_ferr = '1;
    run_cnt   = 0;
    fail_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    do_run(18'o765432, 18'o010101, 21'o7765330, 1, 0, 0);
    do_run('0, '0, '0, 0, 0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
